// File: rtl/e203_exu_fpu_fmis_sqr.sv
// Iterative single-precision squaring unit (rs1*rs1) for the EXU FPU misc group.
// A shift-add significand multiplier retires one multiplier bit per cycle, then one cycle packs the result.
module e203_exu_fpu_fmis_sqr #(
    parameter int MUL_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fmis_sqr_i_valid,
    output logic        fmis_sqr_i_ready,
    input  logic [31:0] fmis_i_rs1,
    output logic        fmis_sqr_o_valid,
    input  logic        fmis_sqr_o_ready,
    output logic [31:0] fmis_sqr_o_wbck_wdat
);

    localparam int PW = 2 * MUL_BITS;
    localparam int CW = $clog2(MUL_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_acc;
    logic [PW-1:0]         r_mcand;
    logic [MUL_BITS-1:0]   r_mplier;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_exp;
    logic [31:0]           r_wdat;
    logic                  r_valid;

    logic [7:0]            w_in_exp;
    logic [MUL_BITS-2:0]   w_in_man;
    logic                  w_accept;
    logic                  w_special;
    logic [31:0]           w_spec_res;
    logic                  w_last;
    logic                  w_hi;
    logic signed [9:0]     w_er;
    logic [MUL_BITS-2:0]   w_mant;
    logic [31:0]           w_norm_res;

    assign w_in_exp  = fmis_i_rs1[30:23];
    assign w_in_man  = fmis_i_rs1[MUL_BITS-2:0];
    assign w_accept  = fmis_sqr_i_valid && (r_state == S_IDLE);
    assign w_special = (w_in_exp == 8'd0) || (w_in_exp == 8'hFF);
    assign w_last    = (r_cnt == CW'(MUL_BITS - 1));

    assign fmis_sqr_i_ready     = (r_state == S_IDLE);
    assign fmis_sqr_o_valid     = r_valid;
    assign fmis_sqr_o_wbck_wdat = r_wdat;

    // Result for zero/subnormal, infinity and NaN operands (sign ignored)
    always_comb begin
        w_spec_res = 32'h0000_0000;
        if (w_in_exp == 8'hFF) begin
            if (w_in_man != '0) begin
                w_spec_res = 32'h7FC0_0000;
            end else begin
                w_spec_res = 32'h7F80_0000;
            end
        end else begin
            w_spec_res = 32'h0000_0000;
        end
    end

    // Product is in [1,4): the top bit selects the normalisation shift; rounding is truncation
    assign w_hi   = r_acc[PW-1];
    assign w_er   = $signed({1'b0, r_exp, 1'b0}) - 10'sd127 + $signed({9'd0, w_hi});
    assign w_mant = w_hi ? r_acc[PW-2 -: (MUL_BITS-1)] : r_acc[PW-3 -: (MUL_BITS-1)];

    // Pack the normalised product, saturating to +inf or flushing to +0
    always_comb begin
        w_norm_res = 32'h0000_0000;
        if (w_er >= 10'sd255) begin
            w_norm_res = 32'h7F80_0000;
        end else if (w_er <= 10'sd0) begin
            w_norm_res = 32'h0000_0000;
        end else begin
            w_norm_res = {1'b0, w_er[7:0], w_mant};
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_nxt = S_NORM;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_NORM: w_state_nxt = S_DONE;
            S_DONE: begin
                if (fmis_sqr_o_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath; the multiplicand is pre-shifted each cycle so it always equals multiplicand<<cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_exp    <= 8'd0;
            r_wdat   <= 32'h0000_0000;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            r_wdat  <= w_spec_res;
                            r_valid <= 1'b1;
                        end else begin
                            r_mcand  <= {{MUL_BITS{1'b0}}, 1'b1, w_in_man};
                            r_mplier <= {1'b1, w_in_man};
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_exp    <= w_in_exp;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_NORM: begin
                    r_wdat  <= w_norm_res;
                    r_valid <= 1'b1;
                end
                S_DONE: begin
                    if (fmis_sqr_o_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_sqr.sv
// Self-checking bench for e203_exu_fpu_fmis_sqr: vector table plus handshake corner sequences.
// Expected results are queued when a request is accepted and popped on each output handshake.
module tb_e203_exu_fpu_fmis_sqr;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] rs1;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] wdat;

    e203_exu_fpu_fmis_sqr #(.MUL_BITS(24)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fmis_sqr_i_valid     (i_valid),
        .fmis_sqr_i_ready     (i_ready),
        .fmis_i_rs1           (rs1),
        .fmis_sqr_o_valid     (o_valid),
        .fmis_sqr_o_ready     (o_ready),
        .fmis_sqr_o_wbck_wdat (wdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] sb_q[$];
    logic [31:0] exp_pending;
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    int          hs_cnt = 0;
    logic        busy_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (i_valid && i_ready) begin
                sb_q.push_back(exp_pending);
                acc_cnt++;
            end
            if (o_valid && o_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %08h with nothing expected", wdat);
                end else begin
                    check("sb_data", wdat, sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request while idle; returns one cycle after the accept edge
    task automatic issue(input logic [31:0] op, input logic [31:0] ex);
        rs1         = op;
        exp_pending = ex;
        i_valid     = 1'b1;
        tick();
        i_valid = 1'b0;
        rs1     = $urandom;
    endtask

    // Count cycles after accept until o_valid rises (bounded)
    task automatic wait_valid(output int n);
        n = 1;
        busy_ready = 1'b0;
        while (!o_valid && n < 100) begin
            if (i_ready) busy_ready = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_acc;
        int base_hs;
        int k;
        logic seen;

        vecs[0]  = '{32'h4000_0000, 32'h4080_0000, 26};
        vecs[1]  = '{32'h3FC0_0000, 32'h4010_0000, 26};
        vecs[2]  = '{32'hC040_0000, 32'h4110_0000, 26};
        vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 26};
        vecs[4]  = '{32'h60AD_78EC, 32'h7F80_0000, 26};
        vecs[5]  = '{32'h1E3C_E508, 32'h0000_0000, 26};
        vecs[6]  = '{32'h7F7F_FFFF, 32'h7F80_0000, 26};
        vecs[7]  = '{32'h5F7F_FFFF, 32'h7F7F_FFFE, 26};
        vecs[8]  = '{32'h5F80_0000, 32'h7F80_0000, 26};
        vecs[9]  = '{32'h2000_0000, 32'h0080_0000, 26};
        vecs[10] = '{32'h1FFF_FFFF, 32'h0000_0000, 26};
        vecs[11] = '{32'h7F80_0001, 32'h7FC0_0000, 1};
        vecs[12] = '{32'hFF80_0000, 32'h7F80_0000, 1};
        vecs[13] = '{32'h8000_0000, 32'h0000_0000, 1};
        vecs[14] = '{32'h0040_0000, 32'h0000_0000, 1};
        vecs[15] = '{32'hFFFF_FFFF, 32'h7FC0_0000, 1};

        rst = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        rs1 = 32'h0;
        exp_pending = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_i_ready", {31'd0, i_ready}, 32'd1);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check("reset_wdat", wdat, 32'h0);
        tick();

        // Reset in the middle of a multiply
        issue(32'h4000_0000, 32'h4080_0000);
        repeat (10) tick();
        check("midop_busy", {31'd0, i_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_rst_i_ready", {31'd0, i_ready}, 32'd1);
        check("midop_rst_wdat", wdat, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            if (o_valid) seen = 1'b1;
            tick();
        end
        check("midop_no_valid", {31'd0, seen}, 32'd0);

        // Vector table, o_ready held high
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].exp);
            wait_valid(n);
            check($sformatf("latency_%0d", i), n, vecs[i].lat);
            check($sformatf("busy_ready_%0d", i), {31'd0, busy_ready}, 32'd0);
            tick();
            check($sformatf("post_valid_%0d", i), {31'd0, o_valid}, 32'd0);
            check($sformatf("post_ready_%0d", i), {31'd0, i_ready}, 32'd1);
        end

        // Backpressure, with a new request already waiting
        o_ready = 1'b0;
        issue(32'h4040_0000, 32'h4110_0000);
        wait_valid(n);
        check("bp_latency", n, 26);
        rs1 = 32'h3FC0_0000;
        exp_pending = 32'h4010_0000;
        i_valid = 1'b1;
        base_hs = hs_cnt;
        repeat (5) begin
            tick();
            check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp_hold_data", wdat, 32'h4110_0000);
            check("bp_hold_i_ready", {31'd0, i_ready}, 32'd0);
        end
        check("bp_no_handshake", hs_cnt - base_hs, 0);
        o_ready = 1'b1;
        tick();
        check("bp_single_hs", hs_cnt - base_hs, 1);
        check("bp_not_same_cycle", {31'd0, o_valid, i_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        rs1 = $urandom;
        wait_valid(n);
        check("bp_next_latency", n, 26);
        tick();

        // Back-to-back with i_valid held high, truncating results
        base_acc = acc_cnt;
        base_hs  = hs_cnt;
        rs1 = 32'h3F80_0001;
        exp_pending = 32'h3F80_0002;
        i_valid = 1'b1;
        tick();
        rs1 = 32'h3FFF_FFFF;
        exp_pending = 32'h407F_FFFE;
        k = 0;
        while (acc_cnt < base_acc + 2 && k < 200) begin
            tick();
            k++;
        end
        i_valid = 1'b0;
        repeat (40) tick();
        check("b2b_accepts", acc_cnt - base_acc, 2);
        check("b2b_handshakes", hs_cnt - base_hs, 2);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
